// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch unit (master) and memory (slave).
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch unit: requests words from instruction memory, hands them
// to decode with a valid/stall handshake, and handles branch redirects,
// including redirects that land while a memory request is still in flight.
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned branch target
// halts fetch and raises a sticky misalign flag; otherwise the target's two
// low bits are cleared).
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_FETCH | request outstanding at pc, waiting for imem_ack
// S_VALID | holding one instruction for decode, no request issued
// S_HALT  | fetch stopped after a misaligned redirect, left only by reset
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_unit_if.master        imem,
  input  logic                branch_taken,
  input  logic [31:0]         branch_target,
  input  logic                stall,
  output logic [31:0]         instruction,
  output logic [31:0]         pc_out,
  output logic                instr_valid,
  output logic                misalign
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_VALID = 2'd1,
    S_HALT  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] drop_target;
  logic        drop;
  // Low for the cycle in which reset is released, so no request goes out and
  // any stray ack is ignored until the first full cycle out of reset.
  logic        run;
  logic [31:0] target;
  logic        target_bad;
  logic        trap;
  logic        ack;

`ifdef FETCH_MISALIGN_TRAP_EN
  assign target     = branch_target;
  assign target_bad = |branch_target[1:0];
`else
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^branch_target[1:0];
  assign target             = {branch_target[31:2], 2'b00};
  assign target_bad         = 1'b0;
`endif

  assign ack  = run && (state == S_FETCH) && imem.imem_ack;
  assign trap = run && branch_taken && target_bad && (state != S_HALT);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    if (run) begin
      case (state)
        S_FETCH: begin
          if (trap) begin
            state_nxt = S_HALT;
          end else if (ack && !branch_taken && !drop) begin
            state_nxt = S_VALID;
          end
        end
        S_VALID: begin
          if (trap) begin
            state_nxt = S_HALT;
          end else if (branch_taken || !stall) begin
            state_nxt = S_FETCH;
          end
        end
        default: state_nxt = state;
      endcase
    end
  end

  // Memory-side outputs: request only while fetching; address is the pc.
  always_comb begin
    imem.imem_req  = run && (state == S_FETCH);
    imem.imem_addr = pc;
  end

  // Datapath: pc, pending-redirect latch and the registered decode outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      run         <= 1'b0;
      pc          <= RESET_PC;
      drop        <= 1'b0;
      drop_target <= RESET_PC;
      instruction <= NOP_INSTR;
      pc_out      <= 32'h0000_0000;
      instr_valid <= 1'b0;
    end else begin
      run <= 1'b1;
      if (run) begin
        case (state)
          S_FETCH: begin
            if (trap) begin
              drop <= 1'b0;
            end else if (ack) begin
              if (branch_taken) begin
                pc   <= target;
                drop <= 1'b0;
              end else if (drop) begin
                pc   <= drop_target;
                drop <= 1'b0;
              end else begin
                instruction <= imem.imem_rdata;
                pc_out      <= pc;
                instr_valid <= 1'b1;
                pc          <= pc + 32'd4;
              end
            end else if (branch_taken) begin
              // Request already issued: keep pc stable, redirect after ack.
              drop        <= 1'b1;
              drop_target <= target;
            end
          end
          S_VALID: begin
            if (trap) begin
              instr_valid <= 1'b0;
              instruction <= NOP_INSTR;
            end else if (branch_taken) begin
              pc          <= target;
              instr_valid <= 1'b0;
              instruction <= NOP_INSTR;
            end else if (!stall) begin
              instr_valid <= 1'b0;
              instruction <= NOP_INSTR;
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;

  // Sticky misaligned-redirect flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      misalign_q <= 1'b0;
    end else if (trap) begin
      misalign_q <= 1'b1;
    end
  end

  assign misalign = misalign_q;
`else
  assign misalign = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by randomized traffic,
// all checked each cycle against a transaction-level model of the fetch rules.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic [31:0] instruction, pc_out;
  logic        instr_valid, misalign;
  logic [31:0] instruction1, pc_out1;
  logic        instr_valid1, misalign1;
  logic        zero_bit;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  fetch_unit_if bus0 ();
  fetch_unit_if bus1 ();

  assign bus1.imem_ack   = bus0.imem_ack;
  assign bus1.imem_rdata = bus0.imem_rdata;
  assign zero_bit        = 1'b0;

  fetch_unit dut0 (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (bus0.master),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .stall        (stall),
    .instruction  (instruction),
    .pc_out       (pc_out),
    .instr_valid  (instr_valid),
    .misalign     (misalign)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut1 (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem         (bus1.master),
    .branch_taken (zero_bit),
    .branch_target(32'h0000_0000),
    .stall        (zero_bit),
    .instruction  (instruction1),
    .pc_out       (pc_out1),
    .instr_valid  (instr_valid1),
    .misalign     (misalign1)
  );

  // Reference model state (dut0, RESET_PC = 0).
  bit          m_live;
  bit          m_have;
  bit          m_halt;
  bit          m_mis;
  logic [31:0] m_pc, m_instr, m_pcout;
  logic [31:0] pend[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fix_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    return t;
`else
    return t & 32'hFFFF_FFFC;
`endif
  endfunction

  function automatic bit bad_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    return (t[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  function automatic bit model_req();
    return m_live && !m_have && !m_halt;
  endfunction

  task automatic model_reset();
    m_live  = 0;
    m_have  = 0;
    m_halt  = 0;
    m_mis   = 0;
    m_pc    = 32'h0;
    m_instr = NOP;
    m_pcout = 32'h0;
    pend.delete();
  endtask

  task automatic model_step(input bit r, input bit a, input logic [31:0] d,
                            input bit b, input logic [31:0] t, input bit s);
    if (!r) begin
      model_reset();
    end else if (!m_live) begin
      m_live = 1;
    end else if (m_halt) begin
      // nothing moves once halted
    end else if (b && bad_target(t)) begin
      m_halt  = 1;
      m_mis   = 1;
      m_have  = 0;
      m_instr = NOP;
      pend.delete();
    end else if (m_have) begin
      if (b) begin
        m_pc    = fix_target(t);
        m_have  = 0;
        m_instr = NOP;
      end else if (!s) begin
        m_have  = 0;
        m_instr = NOP;
      end
    end else if (a) begin
      if (b) begin
        m_pc = fix_target(t);
        pend.delete();
      end else if (pend.size() != 0) begin
        m_pc = pend[0];
        pend.delete();
      end else begin
        m_have  = 1;
        m_instr = d;
        m_pcout = m_pc;
        m_pc    = m_pc + 32'd4;
      end
    end else if (b) begin
      pend.delete();
      pend.push_back(fix_target(t));
    end
  endtask

  task automatic check_outputs();
    chk("imem_req",    {31'b0, bus0.imem_req}, {31'b0, model_req()});
    chk("imem_addr",   bus0.imem_addr, m_pc);
    chk("instr_valid", {31'b0, instr_valid}, {31'b0, m_have});
    chk("instruction", instruction, m_instr);
    chk("pc_out",      pc_out, m_pcout);
    chk("misalign",    {31'b0, misalign}, {31'b0, m_mis});
  endtask

  task automatic cycle(input bit r, input bit a, input logic [31:0] d,
                       input bit b, input logic [31:0] t, input bit s);
    check_outputs();
    rst_n          = r;
    bus0.imem_ack  = a;
    bus0.imem_rdata = d;
    branch_taken   = b;
    branch_target  = t;
    stall          = s;
    @(posedge clk);
    #1;
    model_step(r, a, d, b, t, s);
  endtask

  initial begin
    logic [31:0] rt, rd;
    bit ra, rb, rs, rr;

    rst_n = 1'b0;
    bus0.imem_ack = 1'b0;
    bus0.imem_rdata = 32'h0;
    branch_taken = 1'b0;
    branch_target = 32'h0;
    stall = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();

    // Reset state of both instances.
    chk("rst_req",     {31'b0, bus0.imem_req}, 32'd0);
    chk("rst_addr",    bus0.imem_addr, 32'h0);
    chk("rst_instr",   instruction, NOP);
    chk("rst_pc_out",  pc_out, 32'h0);
    chk("rst_valid",   {31'b0, instr_valid}, 32'd0);
    chk("rst_mis",     {31'b0, misalign}, 32'd0);
    chk("rst1_addr",   bus1.imem_addr, 32'hFFFF_FFFC);
    chk("rst1_req",    {31'b0, bus1.imem_req}, 32'd0);

    // Release cycle with a stray ack (ignored), then basic fetch.
    cycle(1, 1, 32'hDEAD_BEEF, 0, 32'h0, 0);
    chk("first_req",   {31'b0, bus0.imem_req}, 32'd1);
    chk("first_addr",  bus0.imem_addr, 32'h0);
    chk("first1_addr", bus1.imem_addr, 32'hFFFF_FFFC);
    cycle(1, 0, 32'h0, 0, 32'h0, 0);
    cycle(1, 1, 32'h0050_0093, 0, 32'h0, 0);
    chk("basic_instr", instruction, 32'h0050_0093);
    chk("basic_pc",    pc_out, 32'h0);
    chk("basic_valid", {31'b0, instr_valid}, 32'd1);
    chk("wrap_pc_out", pc_out1, 32'hFFFF_FFFC);
    chk("wrap_valid",  {31'b0, instr_valid1}, 32'd1);
    cycle(1, 0, 32'h0, 0, 32'h0, 0);
    chk("basic_next",  bus0.imem_addr, 32'h4);
    chk("basic_drop",  {31'b0, instr_valid}, 32'd0);
    chk("wrap_next",   bus1.imem_addr, 32'h0);
    chk("wrap_req",    {31'b0, bus1.imem_req}, 32'd1);

    // Stall for three cycles while holding the instruction at pc 8.
    cycle(1, 1, 32'h1111_1111, 0, 32'h0, 0);
    cycle(1, 0, 32'h0, 0, 32'h0, 0);
    cycle(1, 1, 32'h2222_2222, 0, 32'h0, 0);
    chk("stall_pc8", pc_out, 32'h8);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 0, 32'h0, 0, 32'h0, 1);
      chk("stall_valid", {31'b0, instr_valid}, 32'd1);
      chk("stall_pc",    pc_out, 32'h8);
      chk("stall_instr", instruction, 32'h2222_2222);
      chk("stall_req",   {31'b0, bus0.imem_req}, 32'd0);
    end
    cycle(1, 0, 32'h0, 0, 32'h0, 0);
    chk("stall_next",  bus0.imem_addr, 32'hC);

    // Redirect while the request at 12 is outstanding; ack two cycles later.
    cycle(1, 0, 32'h0, 1, 32'h100, 0);
    chk("drop_hold",   bus0.imem_addr, 32'hC);
    cycle(1, 0, 32'h0, 0, 32'h0, 0);
    cycle(1, 1, 32'hBAD0_0BAD, 0, 32'h0, 0);
    chk("drop_valid",  {31'b0, instr_valid}, 32'd0);
    chk("drop_addr",   bus0.imem_addr, 32'h100);

    // Redirect in the same cycle as the ack.
    cycle(1, 0, 32'h0, 0, 32'h0, 0);
    cycle(1, 1, 32'h3333_3333, 1, 32'h40, 0);
    chk("same_valid",  {31'b0, instr_valid}, 32'd0);
    chk("same_addr",   bus0.imem_addr, 32'h40);

    // Randomized traffic, including occasional resets.
    for (int n = 0; n < 600; n++) begin
      rr = ($urandom_range(0, 99) != 0);
      ra = model_req() && ($urandom_range(0, 1) == 1);
      rd = $urandom;
      rb = ($urandom_range(0, 7) == 0);
      rt = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      rt = rt & 32'hFFFF_FFFC;
`endif
      rs = ($urandom_range(0, 2) == 0);
      cycle(rr, ra, rd, rb, rt, rs);
    end

    // Reset in the middle of whatever is in progress; ack in the release cycle.
    cycle(1, 0, 32'h0, 0, 32'h0, 0);
    cycle(0, 0, 32'h0, 0, 32'h0, 0);
    cycle(0, 1, 32'h0, 0, 32'h0, 0);
    cycle(1, 1, 32'h4444_4444, 0, 32'h0, 0);
    chk("rel_valid",   {31'b0, instr_valid}, 32'd0);
    chk("rel_req",     {31'b0, bus0.imem_req}, 32'd1);
    chk("rel_addr",    bus0.imem_addr, 32'h0);

    // Misaligned redirect from VALID.
    cycle(1, 1, 32'h5555_5555, 0, 32'h0, 0);
    cycle(1, 0, 32'h0, 1, 32'h102, 0);
`ifdef FETCH_MISALIGN_TRAP_EN
    chk("mis_flag",    {31'b0, misalign}, 32'd1);
    chk("mis_req",     {31'b0, bus0.imem_req}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 32'h6666_6666, (i == 1), 32'h200, 0);
    end
    chk("halt_req",    {31'b0, bus0.imem_req}, 32'd0);
    chk("halt_flag",   {31'b0, misalign}, 32'd1);
    chk("halt_valid",  {31'b0, instr_valid}, 32'd0);
`else
    chk("mis_addr",    bus0.imem_addr, 32'h100);
    chk("mis_flag",    {31'b0, misalign}, 32'd0);
    chk("mis_req",     {31'b0, bus0.imem_req}, 32'd1);
`endif
    cycle(1, 0, 32'h0, 0, 32'h0, 0);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, is the first fetch address after reset.
REQ-003 Parameter NOP_INSTR, default 32'h0000_0013, is the instruction output value when nothing valid is held.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port rst_n  input  1  synchronous active-low reset.
REQ-006 Port imem_req  output  1  instruction memory request.
REQ-007 Port imem_addr  output  32  word-aligned fetch address.
REQ-008 Port imem_ack  input  1  memory response strobe; imem_rdata is valid in the same cycle.
REQ-009 Port imem_rdata  input  32  fetched instruction word.
REQ-010 Port branch_taken  input  1  one-cycle redirect pulse from execute.
REQ-011 Port branch_target  input  32  redirect address.
REQ-012 Port stall  input  1  decode not ready; hold the current instruction.
REQ-013 Port instruction  output  32  instruction to decode.
REQ-014 Port pc_out  output  32  address of instruction.
REQ-015 Port instr_valid  output  1  instruction/pc_out are valid.
REQ-016 Port misalign  output  1  sticky misaligned-target flag.

Function
REQ-017 States: FETCH (imem_req=1, wait for ack), VALID (holding an instruction), HALT (fetch stopped).
REQ-018 In FETCH, imem_req=1, and imem_addr=pc SHALL stay stable until imem_ack.
REQ-019 In FETCH, imem_ack with no redirect pending SHALL register instruction=imem_rdata, pc_out=pc, instr_valid=1, pc=pc+4, and move to VALID on the next edge.
REQ-020 The latency from imem_ack to instr_valid SHALL be 1 cycle.
REQ-021 In VALID, imem_req=0; stall=1 holds all outputs; stall=0 consumes the instruction: instr_valid=0 and instruction=NOP_INSTR next cycle, and the state returns to FETCH.
REQ-022 branch_taken in VALID SHALL drop the held instruction (instr_valid=0 next cycle), set pc=branch_target, and go to FETCH; stall is ignored.
REQ-023 branch_taken in FETCH without imem_ack SHALL latch the target and set a drop flag.
REQ-024 The next imem_ack after REQ-023 SHALL be discarded, and the request SHALL reissue at the latched target the cycle after.
REQ-025 branch_taken in the same cycle as imem_ack SHALL discard that response and set pc=branch_target; FETCH restarts next cycle.
REQ-026 A second branch_taken while the drop flag is set SHALL overwrite the latched target (newest wins).
REQ-027 pc+4 SHALL wrap modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
REQ-028 The pc_out and instruction pair SHALL never change while instr_valid=1 and stall=1, unless branch_taken is asserted.

Reset
REQ-029 While rst_n=0 at a clock edge: pc=RESET_PC, state=FETCH, drop flag=0, imem_req=0, imem_addr=RESET_PC, instruction=NOP_INSTR, pc_out=0, instr_valid=0, misalign=0.
REQ-030 The first imem_req SHALL rise in the first cycle after rst_n is released.
REQ-031 Reset mid-request SHALL abandon the transaction; an imem_ack arriving in the cycle reset is released SHALL be ignored.

Configuration
REQ-032 Macro FETCH_MISALIGN_TRAP_EN.
REQ-033 With FETCH_MISALIGN_TRAP_EN defined: a branch_target with bits [1:0]!=0 SHALL set misalign=1 (sticky until reset), clear instr_valid, enter HALT with imem_req=0, and stay in HALT until reset.
REQ-034 With FETCH_MISALIGN_TRAP_EN undefined: branch_target[1:0] SHALL be forced to 0, misalign SHALL be tied 0, and HALT SHALL be unreachable.

Verification
REQ-035 Reset release, imem_ack one cycle after req, rdata=32'h0050_0093, stall=0 -> imem_addr 0 then 4; instruction=32'h0050_0093 with pc_out=0 for one cycle.
REQ-036 stall=1 for 3 cycles while VALID at pc 8 -> instr_valid, instruction and pc_out constant; imem_req=0; next fetch addr=12 after stall drops.
REQ-037 branch_taken with target 32'h100 while FETCH is waiting, ack after 2 cycles -> response discarded; next imem_addr=32'h100; no instr_valid for the dropped word.
REQ-038 branch_taken and imem_ack in the same cycle, target 32'h40 -> instr_valid stays 0; next request addr=32'h40.
REQ-039 RESET_PC=32'hFFFF_FFFC, one fetch -> pc_out=32'hFFFF_FFFC; next imem_addr=0.
REQ-040 Target 32'h102: with the macro -> misalign=1, imem_req=0 permanently; without the macro -> imem_addr=32'h100, misalign=0.
